// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_HI
   } rx_state_e;

   function automatic int calc_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous RX line; resets to the idle (high) level.
module uart_sync (
   input  logic CLK,
   input  logic RST_N,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_word.sv
// UART receiver that keeps the last two bytes as a 16-bit word (newest in [7:0]).
// Optional even-parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_word
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115_200
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        RX,
   output logic [15:0] WORD,
   output logic        BYTE_VLD,
   output logic [7:0]  BYTE,
   output logic        FRAME_ERR
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

   if (DIV < 4) begin : g_bad_div
      $error("uart_rx_word: CLK_FREQ/BAUD must be at least 4");
   end

   logic          rxs;
   rx_state_e     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          bit_tick;
   logic          frame_ok;

   uart_sync u_sync (
      .CLK   (CLK),
      .RST_N (RST_N),
      .d     (RX),
      .q     (rxs)
   );

   assign bit_tick = (cnt == CNT_LAST);

`ifdef UART_RX_PARITY_EN
   logic par_ok;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         par_ok <= 1'b0;
      end else if (state == PARITY && bit_tick) begin
         par_ok <= ~^{shreg, rxs};
      end
   end

   assign frame_ok = rxs & par_ok;
`else
   assign frame_ok = rxs;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         WORD      <= 16'h0000;
         BYTE      <= 8'h00;
         BYTE_VLD  <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         BYTE_VLD  <= 1'b0;
         FRAME_ERR <= 1'b0;
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            // Mid-start-bit check: a line that is high again was only a glitch.
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rxs ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  cnt     <= '0;
                  shreg   <= {rxs, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (bit_tick) begin
                  cnt   <= '0;
                  state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            // A low stop bit parks in WAIT_HI so a stuck line cannot restart a frame.
            STOP: begin
               if (bit_tick) begin
                  cnt <= '0;
                  if (frame_ok) begin
                     BYTE     <= shreg;
                     WORD     <= {WORD[7:0], shreg};
                     BYTE_VLD <= 1'b1;
                  end else begin
                     FRAME_ERR <= 1'b1;
                  end
                  state <= rxs ? IDLE : WAIT_HI;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_HI: begin
               if (rxs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at DIV = 16; accepted bytes are checked against a word queue.
// Define UART_RX_PARITY_EN for both bench and RTL to exercise the parity build.
module tb_uart_rx_word;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        RX = 1'b1;
   logic [15:0] WORD;
   logic        BYTE_VLD;
   logic [7:0]  BYTE;
   logic        FRAME_ERR;

   int total = 0;
   int bad = 0;
   int vld_cnt = 0;
   int fe_cnt = 0;
   logic [15:0] exp_q[$];
   logic [15:0] model_word = 16'h0000;

   localparam int DIV = 16;

   uart_rx_word #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .RX        (RX),
      .WORD      (WORD),
      .BYTE_VLD  (BYTE_VLD),
      .BYTE      (BYTE),
      .FRAME_ERR (FRAME_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge CLK);
   endtask

   task automatic drive_bit(input logic v);
      RX = v;
      idle(DIV);
   endtask

   // Start, 8 data bits LSB first, optional parity (even, or deliberately wrong), stop.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^b) ^ bad_par);
`endif
      drive_bit(stop_bit);
   endtask

   task automatic send_good(input logic [7:0] b);
      model_word = {model_word[7:0], b};
      exp_q.push_back(model_word);
      send_frame(b, 1'b1, 1'b0);
   endtask

   // Output monitor: pops expected words on BYTE_VLD, counts error pulses.
   always @(negedge CLK) begin
      if (RST_N && (BYTE_VLD || FRAME_ERR)) begin
         check("vld_fe_excl", {31'd0, BYTE_VLD & FRAME_ERR}, 32'd0);
      end
      if (RST_N && FRAME_ERR) fe_cnt++;
      if (RST_N && BYTE_VLD) begin
         vld_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_vld", 32'd1, 32'd0);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check("word", {16'd0, WORD}, {16'd0, e});
            check("byte", {24'd0, BYTE}, {24'd0, e[7:0]});
         end
      end
   end

   initial begin
      // Reset state
      RST_N = 1'b0;
      RX = 1'b1;
      idle(4);
      check("rst_word", {16'd0, WORD}, 32'h0);
      check("rst_byte", {24'd0, BYTE}, 32'h0);
      check("rst_vld", {31'd0, BYTE_VLD}, 32'd0);
      check("rst_fe", {31'd0, FRAME_ERR}, 32'd0);
      RST_N = 1'b1;
      idle(20);

      // Two bytes fill the word
      send_good(8'h3A);
      send_good(8'hC5);
      idle(20);
      check("two_bytes_vld", vld_cnt, 2);
      check("two_bytes_word", {16'd0, WORD}, 32'h3AC5);

      // Short low glitch in IDLE
      RX = 1'b0;
      idle(5);
      RX = 1'b1;
      idle(40);
      check("glitch_vld", vld_cnt, 2);
      check("glitch_fe", fe_cnt, 0);
      check("glitch_word", {16'd0, WORD}, 32'h3AC5);

      // Bad stop bit, line held low afterwards
      send_frame(8'h55, 1'b0, 1'b0);
      idle(40);
      check("stop_err_fe", fe_cnt, 1);
      check("stop_err_vld", vld_cnt, 2);
      check("stop_err_word", {16'd0, WORD}, 32'h3AC5);
      RX = 1'b1;
      idle(40);
      check("stuck_low_fe", fe_cnt, 1);
      check("stuck_low_vld", vld_cnt, 2);

      // Reset during bit 4 of 0xFF
      RX = 1'b0;
      idle(DIV);
      RX = 1'b1;
      idle(4 * DIV + DIV / 2);
      RST_N = 1'b0;
      #1;
      check("midrst_word", {16'd0, WORD}, 32'h0);
      check("midrst_byte", {24'd0, BYTE}, 32'h0);
      idle(3);
      RST_N = 1'b1;
      model_word = 16'h0000;
      idle(20);
      send_good(8'h12);
      idle(20);
      check("after_rst_word", {16'd0, WORD}, 32'h0012);
      check("after_rst_vld", vld_cnt, 3);

      // Back-to-back frames without idle gap
      send_good(8'hA5);
      send_good(8'h5A);
      idle(20);
      check("b2b_word", {16'd0, WORD}, 32'hA55A);
      check("b2b_vld", vld_cnt, 5);

      // Correct parity (or plain frame in the default build)
      send_good(8'h07);
      idle(20);
      check("par_ok_word", {16'd0, WORD}, 32'h5A07);
      check("par_ok_vld", vld_cnt, 6);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1);
      idle(20);
      check("par_bad_fe", fe_cnt, 2);
      check("par_bad_vld", vld_cnt, 6);
      check("par_bad_word", {16'd0, WORD}, 32'h5A07);
`else
      check("total_fe", fe_cnt, 1);
`endif

      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_word.md
UART_RX_WORD -- requirements
Module: uart_rx_word

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning CLK frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, meaning serial bit rate in bit/s.
REQ-003 SHALL have port CLK  input  1  meaning system clock; the only clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port RX  input  1  meaning asynchronous UART line, idle high.
REQ-006 SHALL have port WORD  output  16  meaning last two received bytes, newest in [7:0]; feeds the seven-segment display WORD input.
REQ-007 SHALL have port BYTE_VLD  output  1  meaning one-cycle pulse per accepted byte.
REQ-008 SHALL have port BYTE  output  8  meaning last accepted byte.
REQ-009 SHALL have port FRAME_ERR  output  1  meaning one-cycle pulse per rejected frame.

Function
REQ-010 SHALL compute DIV = CLK_FREQ/BAUD (integer division); elaboration SHALL fail if DIV < 4.
REQ-011 SHALL pass RX through a 2-flop synchronizer; all decisions SHALL use the synchronized value rxs.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HI.
REQ-013 IDLE: on rxs = 0 SHALL go to START and clear the bit-time counter.
REQ-014 START: after DIV/2 cycles SHALL sample rxs; 0 -> DATA, 1 -> IDLE (glitch, no error pulse).
REQ-015 DATA: SHALL sample 8 bits LSB first, one every DIV cycles; after bit 7 -> PARITY if enabled, else STOP.
REQ-016 STOP: DIV cycles after last sample, rxs = 1 SHALL accept the byte; rxs = 0 SHALL reject it and go to WAIT_HI.
REQ-017 On accept, the following cycle SHALL see WORD = {old WORD[7:0], byte}, BYTE = byte, BYTE_VLD = 1 for exactly one cycle; FSM -> IDLE.
REQ-018 On reject, FRAME_ERR SHALL pulse one cycle; WORD, BYTE unchanged.
REQ-019 WAIT_HI SHALL stay until rxs = 1, then -> IDLE, preventing a stuck-low line from re-triggering.
REQ-020 Bit-time counter SHALL be $clog2(DIV) bits wide and SHALL wrap to 0 at DIV-1 without overflow.
REQ-021 BYTE_VLD and FRAME_ERR SHALL never assert in the same cycle.

Reset
REQ-022 RST_N low SHALL immediately force FSM = IDLE, WORD = 16'h0000, BYTE = 8'h00, BYTE_VLD = 0, FRAME_ERR = 0, counters 0, synchronizer flops 1.
REQ-023 Reset mid-frame SHALL discard the partial byte; after release, the next falling edge of rxs SHALL start a new frame.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: PARITY state SHALL sample one bit DIV cycles after bit 7; the frame SHALL be rejected (REQ-018) unless data plus parity has even parity.
REQ-025 Macro UART_RX_PARITY_EN undefined: PARITY state and parity logic SHALL be absent; frame = start, 8 data bits, stop.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enum and the constant function computing DIV from CLK_FREQ and BAUD.
REQ-027 The 2-flop synchronizer SHALL be a sub-module uart_sync (reset value 1); all other logic stays in uart_rx_word.

Verification (CLK_FREQ = 1_600_000, BAUD = 100_000, DIV = 16)
REQ-028 Reset then send 0x3A, then 0xC5 -> BYTE_VLD pulses twice; WORD = 0x003A, then 0x3AC5.
REQ-029 RX low for 5 cycles in IDLE -> no BYTE_VLD, no FRAME_ERR; WORD unchanged.
REQ-030 Send 0x55 with stop bit 0, line held low for 40 cycles -> one FRAME_ERR pulse, WORD unchanged, no new frame until RX returns high.
REQ-031 Assert RST_N low during bit 4 of 0xFF -> WORD = 0x0000 at once; following 0x12 -> WORD = 0x0012.
REQ-032 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> accepted; with parity bit 0 -> FRAME_ERR, WORD unchanged.
REQ-033 Back-to-back frames 0xA5, 0x5A with no idle gap between stop and next start -> both accepted, WORD = 0xA55A.
